// File: rtl/secp256k1_inv_arbiter.sv
// Purpose: round-robin share of one secp256k1 modular inverter among N_REQ requesters, tagged responses.
// Latency: grant T -> inv_start T+1; rsp_valid the cycle after inv_done; zero operand -> rsp_valid T+1.
// Backpressure: one op in flight; req_ready only in IDLE; rsp_* held until rsp_ready; no grant while orphan run pending.
module secp256k1_inv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 2048
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*256-1:0]   req_a,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   inv_start,
    output logic [255:0]           inv_a,
    input  logic [255:0]           inv_result,
    input  logic                   inv_done,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [255:0]           rsp_result,
    output logic                   rsp_err,
    input  logic                   rsp_ready,
    output logic                   busy
);

    localparam int              PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int              TW     = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            pending_q, pending_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [255:0]    inv_a_q, inv_a_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [255:0]    rsp_result_q, rsp_result_d;
    logic            rsp_err_q, rsp_err_d;

    logic [2*N_REQ-1:0] dbl_valid;
    logic [N_REQ-1:0]   rot_valid;
    logic [PW-1:0]      gnt_off;
    logic [PW:0]        gnt_sum;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic [255:0]       gnt_a;
    logic               gnt_ok;

    // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take lowest set bit, rotate index back.
    always_comb begin
        dbl_valid = {req_valid, req_valid} >> rr_ptr_q;
        rot_valid = dbl_valid[N_REQ-1:0];
        gnt_vld   = |rot_valid;
        gnt_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                gnt_off = PW'(k);
            end
        end
        gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
        if (gnt_sum >= (PW+1)'(N_REQ)) begin
            gnt_sum = gnt_sum - (PW+1)'(N_REQ);
        end
        gnt_idx = gnt_sum[PW-1:0];
        gnt_a   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx == PW'(k)) begin
                gnt_a = req_a[k*256 +: 256];
            end
        end
        // A grant needs IDLE and no orphaned inverter run, since the inverter ignores start while busy.
        gnt_ok    = (state_q == S_IDLE) && !pending_q && gnt_vld;
        req_ready = gnt_ok ? (N_REQ'(1) << gnt_idx) : '0;
    end

    // Next-state and handshake outputs for the grant/issue/wait/respond sequence.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        pending_d    = pending_q;
        timer_d      = timer_q;
        inv_a_d      = inv_a_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        inv_start    = 1'b0;
        rsp_valid    = 1'b0;

        // A done outside WAIT belongs to a run that already timed out; it only frees the inverter.
        if (inv_done && (state_q != S_WAIT)) begin
            pending_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (gnt_ok) begin
                    inv_a_d  = gnt_a;
                    rsp_id_d = ID_W'(gnt_idx);
                    rr_ptr_d = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
                    if (gnt_a == '0) begin
                        rsp_result_d = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                inv_start = 1'b1;
                timer_d   = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (inv_done) begin
                    rsp_result_d = inv_result;
                    rsp_err_d    = 1'b0;
                    state_d      = S_RESP;
                end else if (timer_q == T_LAST) begin
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    pending_d    = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            pending_q    <= 1'b0;
            timer_q      <= '0;
            inv_a_q      <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            pending_q    <= pending_d;
            timer_q      <= timer_d;
            inv_a_q      <= inv_a_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign inv_a      = inv_a_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != S_IDLE) || pending_q;

endmodule

// File: tb/tb_secp256k1_inv_arbiter.sv
// Purpose: randomized + directed bench for secp256k1_inv_arbiter against a cycle-level reference model.
// Latency: model predicts grant, inv_start and rsp_valid cycles from the arbitration rules.
// Backpressure: rsp_ready randomly withheld; stub inverter with random latency or hang.
module tb_secp256k1_inv_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 16;
    localparam int BIG = 1 << 30;
    localparam logic [255:0] P    = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] HALF = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*256-1:0] req_a;
    logic [N-1:0]     req_ready;
    logic             inv_start;
    logic [255:0]     inv_a;
    logic [255:0]     inv_result;
    logic             inv_done;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [255:0]     rsp_result;
    logic             rsp_err;
    logic             rsp_ready;
    logic             busy;

    always #5 clk = ~clk;

    secp256k1_inv_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready),
        .inv_start(inv_start), .inv_a(inv_a), .inv_result(inv_result), .inv_done(inv_done),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Fermat inverse a^(p-2) mod p.
    function automatic logic [255:0] modinv(input logic [255:0] a);
        logic [511:0] r, b, pp;
        logic [255:0] e;
        pp = {256'b0, P};
        e  = P - 256'd2;
        r  = 512'd1;
        b  = {256'b0, a} % pp;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = (r * b) % pp;
            b = (b * b) % pp;
        end
        return r[255:0];
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (((v >> ((ptr + k) % N)) & N'(1)) != '0) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Stub inverter: random latency 1..10 cycles, or hang; manual_req forces a stray done pulse.
    int start_cnt  = 0;
    bit stub_hang  = 1'b0;
    int manual_req = 0;
    initial begin : stub
        int cnt;
        int manual_seen;
        logic [255:0] held;
        cnt = 0; manual_seen = 0; held = '0;
        inv_done = 1'b0; inv_result = '0;
        forever begin
            @(negedge clk);
            inv_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        inv_done = 1'b1;
                        inv_result = modinv(held);
                    end
                end
                if (inv_start) begin
                    start_cnt++;
                    held = inv_a;
                    if (!stub_hang) cnt = $urandom_range(1, 10);
                end
                if (manual_req != manual_seen) begin
                    manual_seen = manual_req;
                    inv_done = 1'b1;
                    inv_result = {8{$urandom}};
                end
            end
        end
    end

    // Reference model state.
    int cyc = 0;
    bit inflight, ref_pending, exp_err;
    int rr, rsp_at, start_at, grant_cyc, exp_id;
    logic [255:0] exp_a, exp_res, last_res;
    logic [IDW-1:0] last_id;
    logic last_err;
    int glog[$];

    task automatic model_reset();
        inflight = 0; ref_pending = 0; rr = 0; rsp_at = BIG; start_at = -1;
        grant_cyc = 0; exp_id = 0; exp_a = '0; exp_res = '0; exp_err = 0;
    endtask

    // One clock: check DUT against model just before the edge, then advance model.
    task automatic tick();
        int g;
        logic [N-1:0] er;
        bit rup;
        @(negedge clk); #3;
        er = '0; g = -1;
        if (!inflight && !ref_pending) begin
            g = pick(req_valid, rr);
            if (g >= 0) er = N'(1) << g;
        end
        chk("req_ready", req_ready, er);
        chk("onehot", $onehot0(req_ready), 1);
        chk("busy", busy, inflight || ref_pending);
        chk("inv_start", inv_start, cyc == start_at);
        rup = inflight && (cyc >= rsp_at);
        chk("rsp_valid", rsp_valid, rup);
        if (rup) begin
            chk("rsp_id", rsp_id, exp_id);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_result", rsp_result, exp_res);
            last_res = rsp_result; last_id = rsp_id; last_err = rsp_err;
        end
        if (inflight && exp_a != '0 && cyc > grant_cyc) chk("inv_a", inv_a, exp_a);
        if (rup && rsp_ready) begin
            inflight = 0;
            if (exp_err && exp_a != '0) ref_pending = 1;
            rsp_at = BIG;
        end else if (inflight && inv_done && rsp_at == BIG) begin
            rsp_at = cyc + 1;
        end
        if (inv_done && ref_pending && !inflight) ref_pending = 0;
        if (g >= 0) begin
            glog.push_back(g);
            exp_id = g; grant_cyc = cyc; inflight = 1; rr = (g + 1) % N;
            exp_a = 256'(req_a >> (g * 256));
            if (exp_a == '0) begin
                exp_err = 1; exp_res = '0; rsp_at = cyc + 1;
            end else begin
                start_at = cyc + 1;
                if (stub_hang) begin
                    exp_err = 1; exp_res = '0; rsp_at = cyc + 2 + TO;
                end else begin
                    exp_err = 0; exp_res = modinv(exp_a); rsp_at = BIG;
                end
            end
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (inflight && n < 100) begin tick(); n++; end
        chk("idle_bound", n < 100, 1);
    endtask

    task automatic do_req(input int idx, input logic [255:0] a);
        int n;
        req_a[idx*256 +: 256] = a;
        req_valid[idx] = 1'b1;
        n = 0;
        while (!inflight && n < 50) begin tick(); n++; end
        chk("grant_bound", n < 50, 1);
        req_valid[idx] = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        int n, prev, s0;
        bit reas[2];
        int exp_order[6];
        exp_order = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b0; req_valid = '0; req_a = '0; rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_inv_start", inv_start, 0);
        chk("rst_inv_a", inv_a, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Directed operands.
        do_req(0, 256'd1);
        chk("a1_result", last_res, 256'd1);
        chk("a1_id", last_id, 0);
        chk("a1_starts", start_cnt, 1);
        do_req(2, 256'd2);
        chk("a2_result", last_res, HALF);
        chk("a2_id", last_id, 2);
        chk("a2_starts", start_cnt, 2);
        do_req(1, 256'd0);
        chk("a0_result", last_res, 0);
        chk("a0_err", last_err, 1);
        chk("a0_starts", start_cnt, 2);

        // Round-robin order with 0 and 1 re-requesting.
        do_reset();
        glog.delete();
        for (int i = 0; i < N; i++) req_a[i*256 +: 256] = {8{$urandom}} | 256'd1;
        req_valid = '1; reas = '{0, 0}; n = 0; prev = 0;
        while (glog.size() < 6 && n < 400) begin
            tick(); n++;
            if (glog.size() > prev) begin
                prev = glog.size();
                req_valid[glog[$]] = 1'b0;
                if (glog[$] < 2 && !reas[glog[$]]) begin
                    reas[glog[$]] = 1'b1;
                    req_valid[glog[$]] = 1'b1;
                end
            end
        end
        chk("rr_bound", n < 400, 1);
        wait_idle();
        for (int i = 0; i < 6; i++) chk("rr_order", (glog.size() > i) ? glog[i] : -1, exp_order[i]);

        // Response backpressure.
        rsp_ready = 1'b0;
        req_a[3*256 +: 256] = {8{$urandom}} | 256'd1;
        req_valid = 4'b1000;
        n = 0;
        while (!inflight && n < 20) begin tick(); n++; end
        req_valid = 4'b0011;
        n = 0;
        while (!(inflight && cyc >= rsp_at) && n < 50) begin tick(); n++; end
        chk("bp_rsp_bound", n < 50, 1);
        repeat (10) tick();
        chk("bp_held_id", last_id, 3);
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("bp_next_grant", glog[$], 0);
        req_valid = '0;
        wait_idle();

        // Watchdog timeout with a hung inverter, then a stray done that must not be reported.
        stub_hang = 1'b1;
        s0 = start_cnt;
        do_req(1, {8{$urandom}} | 256'd1);
        chk("to_err", last_err, 1);
        chk("to_result", last_res, 0);
        chk("to_starts", start_cnt, s0 + 1);
        req_valid = '1;
        repeat (10) tick();
        chk("to_busy", busy, 1);
        chk("to_no_grant", req_ready, 0);
        stub_hang = 1'b0;
        manual_req++;
        n = 0;
        while (!inflight && n < 20) begin tick(); n++; end
        chk("to_regrant_bound", n < 20, 1);
        req_valid = '0;
        wait_idle();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                req_a[i*256 +: 256] = ($urandom_range(0, 7) == 0) ? 256'd0 : {8{$urandom}};
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
